// File: rtl/clause_array_scan.sv
// clause_array_scan: clause store plus sequential BCP evaluator, one clause per cycle.
// Optional feature: define CLAUSE_ARRAY_EARLY_EXIT_EN to end the scan at the first conflicting clause.
module clause_array_scan #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4,
  parameter int CID_W       = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
  parameter int VID_W       = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_VARS*3-1:0]           var_value_i,
  input  logic [NUM_VARS*WIDTH_LVL-1:0]   var_lvl_i,
  input  logic [NUM_CLAUSES-1:0]          wr_i,
  input  logic [NUM_CLAUSES-1:0]          rd_i,
  input  logic [NUM_VARS*2-1:0]           clause_i,
  input  logic [WIDTH_C_LEN-1:0]          clause_len_i,
  output logic [NUM_VARS*2-1:0]           clause_o,
  output logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_o,
  input  logic                            apply_imply_i,
  input  logic                            apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]            bkt_lvl_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            imply_valid_o,
  output logic                            conflict_o,
  output logic [VID_W-1:0]                imply_var_o,
  output logic [1:0]                      imply_value_o,
  output logic [WIDTH_LVL-1:0]            imply_lvl_o,
  output logic [WIDTH_LVL-1:0]            conflict_lvl_o,
  output logic [CID_W-1:0]                imply_cid_o,
  output logic [CID_W-1:0]                conflict_cid_o,
  output logic                            all_c_sat_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  state_e state_q, state_d;

  logic [NUM_VARS*2-1:0]         clause_q     [NUM_CLAUSES];
  logic [WIDTH_C_LEN-1:0]        len_q        [NUM_CLAUSES];
  logic [WIDTH_LVL-1:0]          reason_lvl_q [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0]        reason_q;

  logic [NUM_VARS*2-1:0]         val_q;
  logic [NUM_VARS*WIDTH_LVL-1:0] lvl_q;
  logic [CID_W-1:0]              idx_q;

  // Running "first found" state across the scan
  logic                 sc_conf_q, sc_unit_q, sc_sat_q;
  logic [CID_W-1:0]     sc_conf_cid_q, sc_unit_cid_q;
  logic [WIDTH_LVL-1:0] sc_conf_lvl_q, sc_unit_lvl_q;
  logic [VID_W-1:0]     sc_unit_var_q;
  logic [1:0]           sc_unit_val_q;

  logic                 res_conf_q, res_valid_q, res_sat_q;
  logic [CID_W-1:0]     res_conf_cid_q, res_imp_cid_q;
  logic [WIDTH_LVL-1:0] res_conf_lvl_q, res_imp_lvl_q;
  logic [VID_W-1:0]     res_imp_var_q;
  logic [1:0]           res_imp_val_q;

  logic [NUM_VARS*2-1:0] cur_lits;
  logic [1:0]            lit_j, val_j;
  logic [WIDTH_LVL-1:0]  lvl_j;
  logic                  cur_empty, cur_sat, cur_has_free, cur_multi_free;
  logic                  cur_unit, cur_conf;
  logic [VID_W-1:0]      cur_free_var;
  logic [1:0]            cur_free_val;
  logic [WIDTH_LVL-1:0]  cur_false_lvl, cur_all_lvl;

  logic                 m_conf, m_unit, m_sat;
  logic [CID_W-1:0]     m_conf_cid, m_unit_cid;
  logic [WIDTH_LVL-1:0] m_conf_lvl, m_unit_lvl;
  logic [VID_W-1:0]     m_unit_var;
  logic [1:0]           m_unit_val;

  logic last_idx, early_hit, scan_exit, start, commit;
  logic [NUM_VARS-1:0] unused_val_bits;

  always_comb begin
    cur_lits       = clause_q[idx_q];
    lit_j          = '0;
    val_j          = '0;
    lvl_j          = '0;
    cur_empty      = 1'b1;
    cur_sat        = 1'b0;
    cur_has_free   = 1'b0;
    cur_multi_free = 1'b0;
    cur_free_var   = '0;
    cur_free_val   = '0;
    cur_false_lvl  = '0;
    cur_all_lvl    = '0;
    for (int unsigned j = 0; j < NUM_VARS; j++) begin
      lit_j = cur_lits[2*j +: 2];
      val_j = val_q[2*j +: 2];
      lvl_j = lvl_q[WIDTH_LVL*j +: WIDTH_LVL];
      if (lit_j == 2'b01 || lit_j == 2'b10) begin
        cur_empty = 1'b0;
        if (lvl_j > cur_all_lvl) cur_all_lvl = lvl_j;
        if (val_j == 2'b00 || val_j == 2'b11) begin
          if (cur_has_free) cur_multi_free = 1'b1;
          cur_has_free = 1'b1;
          cur_free_var = VID_W'(j);
          cur_free_val = lit_j;
        end else if (val_j == lit_j) begin
          cur_sat = 1'b1;
        end else if (lvl_j > cur_false_lvl) begin
          cur_false_lvl = lvl_j;
        end
      end
    end
    cur_unit = !cur_sat && cur_has_free && !cur_multi_free;
    cur_conf = !cur_empty && !cur_sat && !cur_has_free;
  end

  always_comb begin
    m_conf     = sc_conf_q;
    m_conf_cid = sc_conf_cid_q;
    m_conf_lvl = sc_conf_lvl_q;
    m_unit     = sc_unit_q;
    m_unit_cid = sc_unit_cid_q;
    m_unit_lvl = sc_unit_lvl_q;
    m_unit_var = sc_unit_var_q;
    m_unit_val = sc_unit_val_q;
    m_sat      = sc_sat_q & (cur_empty | cur_sat);
    if (!sc_conf_q && cur_conf) begin
      m_conf     = 1'b1;
      m_conf_cid = idx_q;
      m_conf_lvl = cur_all_lvl;
    end
    if (!sc_unit_q && cur_unit) begin
      m_unit     = 1'b1;
      m_unit_cid = idx_q;
      m_unit_lvl = cur_false_lvl;
      m_unit_var = cur_free_var;
      m_unit_val = cur_free_val;
    end
  end

`ifdef CLAUSE_ARRAY_EARLY_EXIT_EN
  assign early_hit = cur_conf;
`else
  assign early_hit = 1'b0;
`endif

  assign last_idx  = (idx_q == CID_W'(NUM_CLAUSES - 1));
  assign scan_exit = (state_q == SCAN) && (last_idx || early_hit);
  assign start     = (state_q == IDLE) && apply_imply_i && !apply_bkt_i;
  assign commit    = scan_exit && !apply_bkt_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (apply_imply_i && !apply_bkt_i) state_d = SCAN;
      SCAN: begin
        if (apply_bkt_i)    state_d = IDLE;
        else if (scan_exit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
        clause_q[i]     <= '0;
        len_q[i]        <= '0;
        reason_lvl_q[i] <= '0;
      end
      reason_q       <= '0;
      val_q          <= '0;
      lvl_q          <= '0;
      idx_q          <= '0;
      sc_conf_q      <= 1'b0;
      sc_unit_q      <= 1'b0;
      sc_sat_q       <= 1'b0;
      sc_conf_cid_q  <= '0;
      sc_unit_cid_q  <= '0;
      sc_conf_lvl_q  <= '0;
      sc_unit_lvl_q  <= '0;
      sc_unit_var_q  <= '0;
      sc_unit_val_q  <= '0;
      res_conf_q     <= 1'b0;
      res_valid_q    <= 1'b0;
      res_sat_q      <= 1'b0;
      res_conf_cid_q <= '0;
      res_imp_cid_q  <= '0;
      res_conf_lvl_q <= '0;
      res_imp_lvl_q  <= '0;
      res_imp_var_q  <= '0;
      res_imp_val_q  <= '0;
    end else begin
      if (start) begin
        for (int unsigned j = 0; j < NUM_VARS; j++) val_q[2*j +: 2] <= var_value_i[3*j +: 2];
        lvl_q          <= var_lvl_i;
        idx_q          <= '0;
        sc_conf_q      <= 1'b0;
        sc_unit_q      <= 1'b0;
        sc_sat_q       <= 1'b1;
        sc_conf_cid_q  <= '0;
        sc_unit_cid_q  <= '0;
        sc_conf_lvl_q  <= '0;
        sc_unit_lvl_q  <= '0;
        sc_unit_var_q  <= '0;
        sc_unit_val_q  <= '0;
        res_conf_q     <= 1'b0;
        res_valid_q    <= 1'b0;
        res_sat_q      <= 1'b0;
        res_conf_cid_q <= '0;
        res_imp_cid_q  <= '0;
        res_conf_lvl_q <= '0;
        res_imp_lvl_q  <= '0;
        res_imp_var_q  <= '0;
        res_imp_val_q  <= '0;
      end
      if (state_q == SCAN) begin
        idx_q         <= idx_q + 1'b1;
        sc_conf_q     <= m_conf;
        sc_conf_cid_q <= m_conf_cid;
        sc_conf_lvl_q <= m_conf_lvl;
        sc_unit_q     <= m_unit;
        sc_unit_cid_q <= m_unit_cid;
        sc_unit_lvl_q <= m_unit_lvl;
        sc_unit_var_q <= m_unit_var;
        sc_unit_val_q <= m_unit_val;
        sc_sat_q      <= m_sat;
      end
      // Results are committed on the edge leaving SCAN so they appear together with done_o.
      if (commit) begin
        res_conf_q     <= m_conf;
        res_conf_cid_q <= m_conf_cid;
        res_conf_lvl_q <= m_conf_lvl;
        res_sat_q      <= m_sat;
        if (!m_conf && m_unit) begin
          res_valid_q                <= 1'b1;
          res_imp_cid_q              <= m_unit_cid;
          res_imp_lvl_q              <= m_unit_lvl;
          res_imp_var_q              <= m_unit_var;
          res_imp_val_q              <= m_unit_val;
          reason_q[m_unit_cid]       <= 1'b1;
          reason_lvl_q[m_unit_cid]   <= m_unit_lvl;
        end
      end
      for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
        if (state_q == IDLE && wr_i[i]) begin
          clause_q[i] <= clause_i;
          len_q[i]    <= clause_len_i;
          reason_q[i] <= 1'b0;
        end
        if (apply_bkt_i && reason_lvl_q[i] > bkt_lvl_i) reason_q[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    clause_o        = '0;
    clause_len_o    = '0;
    unused_val_bits = '0;
    for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
      if (rd_i[i]) clause_o = clause_o | clause_q[i];
      clause_len_o[WIDTH_C_LEN*i +: WIDTH_C_LEN] = reason_q[i] ? '0 : len_q[i];
    end
    for (int unsigned j = 0; j < NUM_VARS; j++) unused_val_bits[j] = var_value_i[3*j+2];
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign imply_valid_o  = res_valid_q;
  assign conflict_o     = res_conf_q;
  assign imply_var_o    = res_imp_var_q;
  assign imply_value_o  = res_imp_val_q;
  assign imply_lvl_o    = res_imp_lvl_q;
  assign imply_cid_o    = res_imp_cid_q;
  assign conflict_lvl_o = res_conf_lvl_q;
  assign conflict_cid_o = res_conf_cid_q;
  assign all_c_sat_o    = res_sat_q;

endmodule

// File: tb/tb_clause_array_scan.sv
// Self-checking bench for clause_array_scan: directed scenarios plus randomized scans vs a clause-level model.
module tb_clause_array_scan;
  localparam int NV = 8, NC = 8, WL = 16, WCL = 4, CW = 3, VW = 3;
`ifdef CLAUSE_ARRAY_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [NV*3-1:0] var_value_i = '0;
  logic [NV*WL-1:0] var_lvl_i = '0;
  logic [NC-1:0] wr_i = '0, rd_i = '0;
  logic [NV*2-1:0] clause_i = '0, clause_o;
  logic [WCL-1:0] clause_len_i = '0;
  logic [WCL*NC-1:0] clause_len_o;
  logic apply_imply_i = 1'b0, apply_bkt_i = 1'b0;
  logic [WL-1:0] bkt_lvl_i = '0;
  logic busy_o, done_o, imply_valid_o, conflict_o, all_c_sat_o;
  logic [VW-1:0] imply_var_o;
  logic [1:0] imply_value_o;
  logic [WL-1:0] imply_lvl_o, conflict_lvl_o;
  logic [CW-1:0] imply_cid_o, conflict_cid_o;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  clause_array_scan #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_LVL(WL), .WIDTH_C_LEN(WCL)) dut (
    .clk(clk), .rst(rst), .var_value_i(var_value_i), .var_lvl_i(var_lvl_i),
    .wr_i(wr_i), .rd_i(rd_i), .clause_i(clause_i), .clause_len_i(clause_len_i),
    .clause_o(clause_o), .clause_len_o(clause_len_o),
    .apply_imply_i(apply_imply_i), .apply_bkt_i(apply_bkt_i), .bkt_lvl_i(bkt_lvl_i),
    .busy_o(busy_o), .done_o(done_o), .imply_valid_o(imply_valid_o), .conflict_o(conflict_o),
    .imply_var_o(imply_var_o), .imply_value_o(imply_value_o), .imply_lvl_o(imply_lvl_o),
    .conflict_lvl_o(conflict_lvl_o), .imply_cid_o(imply_cid_o), .conflict_cid_o(conflict_cid_o),
    .all_c_sat_o(all_c_sat_o));

  // Reference state
  logic [NV*2-1:0] m_clause [NC];
  logic [WCL-1:0]  m_len    [NC];
  bit              r_flag   [NC];
  int              r_lvl    [NC];
  logic [1:0]      m_val    [NV];
  int              m_lvl    [NV];

  bit ex_conf, ex_unit, ex_valid, ex_sat;
  int ex_ccid, ex_clvl, ex_icid, ex_ilvl, ex_ivar, ex_ival, ex_cyc;
  int ob_conf, ob_valid, ob_sat, ob_ccid, ob_clvl, ob_icid, ob_ilvl, ob_ivar, ob_ival, ob_cyc;
  int ob_busy1, ob_done2, ob_busy2;

  function automatic logic [NV*2-1:0] mk(int v, logic [1:0] l);
    logic [NV*2-1:0] r;
    r = '0;
    r[2*v +: 2] = l;
    return r;
  endfunction

  function automatic logic [WCL*NC-1:0] exp_lens();
    logic [WCL*NC-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[WCL*c +: WCL] = r_flag[c] ? '0 : m_len[c];
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin m_clause[c] = '0; m_len[c] = '0; r_flag[c] = 0; r_lvl[c] = 0; end
    for (int v = 0; v < NV; v++) begin m_val[v] = 2'b00; m_lvl[v] = 0; end
  endtask

  task automatic model_scan();
    ex_conf = 0; ex_unit = 0; ex_sat = 1;
    ex_ccid = 0; ex_clvl = 0; ex_icid = 0; ex_ilvl = 0; ex_ivar = 0; ex_ival = 0;
    for (int c = 0; c < NC; c++) begin
      int npres, nfree, ntrue, fvar, fval, maxf, maxa;
      logic [1:0] l;
      npres = 0; nfree = 0; ntrue = 0; fvar = 0; fval = 0; maxf = 0; maxa = 0;
      for (int v = 0; v < NV; v++) begin
        l = m_clause[c][2*v +: 2];
        if (l == 2'b01 || l == 2'b10) begin
          npres++;
          if (m_lvl[v] > maxa) maxa = m_lvl[v];
          if (m_val[v] == 2'b00 || m_val[v] == 2'b11) begin nfree++; fvar = v; fval = int'(l); end
          else if (m_val[v] == l) ntrue++;
          else if (m_lvl[v] > maxf) maxf = m_lvl[v];
        end
      end
      if (npres > 0 && ntrue == 0) begin
        ex_sat = 0;
        if (nfree == 0 && !ex_conf) begin ex_conf = 1; ex_ccid = c; ex_clvl = maxa; end
        if (nfree == 1 && !ex_unit) begin ex_unit = 1; ex_icid = c; ex_ilvl = maxf; ex_ivar = fvar; ex_ival = fval; end
      end
    end
    ex_valid = ex_unit && !ex_conf;
    ex_cyc = (EARLY && ex_conf) ? ex_ccid + 2 : NC + 1;
  endtask

  task automatic drive_vars();
    for (int v = 0; v < NV; v++) begin
      var_value_i[3*v +: 3] = {1'($urandom_range(0, 1)), m_val[v]};
      var_lvl_i[WL*v +: WL] = WL'(m_lvl[v]);
    end
  endtask

  task automatic wr_clause(int slot, logic [NV*2-1:0] lits, logic [WCL-1:0] len);
    wr_i = '0; wr_i[slot] = 1'b1; clause_i = lits; clause_len_i = len;
    @(posedge clk); @(negedge clk);
    wr_i = '0;
    m_clause[slot] = lits; m_len[slot] = len; r_flag[slot] = 0;
  endtask

  task automatic do_bkt(int lvl);
    apply_bkt_i = 1'b1; bkt_lvl_i = WL'(lvl);
    @(posedge clk); @(negedge clk);
    apply_bkt_i = 1'b0;
    for (int c = 0; c < NC; c++) if (r_flag[c] && r_lvl[c] > lvl) r_flag[c] = 0;
  endtask

  // Starts a scan at the next edge (edge 0) and records the cycle number at which done_o is seen.
  task automatic run_scan();
    drive_vars();
    model_scan();
    apply_imply_i = 1'b1;
    @(posedge clk); @(negedge clk);
    apply_imply_i = 1'b0;
    ob_busy1 = int'(busy_o);
    ob_cyc = -1;
    for (int c = 1; c <= NC + 4; c++) begin
      if (done_o === 1'b1) begin ob_cyc = c; break; end
      @(posedge clk); @(negedge clk);
    end
    ob_conf = int'(conflict_o); ob_valid = int'(imply_valid_o); ob_sat = int'(all_c_sat_o);
    ob_ccid = int'(conflict_cid_o); ob_clvl = int'(conflict_lvl_o);
    ob_icid = int'(imply_cid_o); ob_ilvl = int'(imply_lvl_o);
    ob_ivar = int'(imply_var_o); ob_ival = int'(imply_value_o);
    @(posedge clk); @(negedge clk);
    ob_done2 = int'(done_o); ob_busy2 = int'(busy_o);
    if (ex_valid) begin r_flag[ex_icid] = 1; r_lvl[ex_icid] = ex_ilvl; end
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, imply_valid_o, conflict_o, imply_var_o, imply_value_o, imply_lvl_o,
         conflict_lvl_o, imply_cid_o, conflict_cid_o, all_c_sat_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got busy=%b done=%b iv=%b cf=%b sat=%b exp all 0",
                           busy_o, done_o, imply_valid_o, conflict_o, all_c_sat_o);
    end
    checks++;
    if (clause_o !== '0 || clause_len_o !== '0) begin
      failures++; $display("FAIL reset_store got clause_o=%h len=%h exp 0", clause_o, clause_len_o);
    end
    rd_i = '0; rst = 1'b1;
    model_clear();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_conflict();
    m_val[0] = 2'b10; m_lvl[0] = 3; m_val[1] = 2'b01; m_lvl[1] = 2;
    wr_clause(0, mk(0, 2'b01) | mk(1, 2'b10), 4'd2);
    run_scan();
    checks++; if (ob_conf !== 1) begin failures++; $display("FAIL conflict_flag got=%0d exp=1", ob_conf); end
    checks++; if (ob_ccid !== ex_ccid) begin failures++; $display("FAIL conflict_cid got=%0d exp=%0d", ob_ccid, ex_ccid); end
    checks++; if (ob_clvl !== ex_clvl) begin failures++; $display("FAIL conflict_lvl got=%0d exp=%0d", ob_clvl, ex_clvl); end
    checks++; if (ob_cyc !== ex_cyc) begin failures++; $display("FAIL conflict_done_cycle got=%0d exp=%0d", ob_cyc, ex_cyc); end
    checks++; if (ob_valid !== 0) begin failures++; $display("FAIL conflict_implyvalid got=%0d exp=0", ob_valid); end
  endtask

  task automatic test_imply_bkt();
    m_val[0] = 2'b10; m_lvl[0] = 5; m_val[1] = 2'b10; m_lvl[1] = 1; m_val[3] = 2'b00;
    wr_clause(2, mk(0, 2'b01) | mk(3, 2'b01), 4'd2);
    run_scan();
    checks++; if (ob_valid !== 1 || ob_conf !== 0) begin failures++; $display("FAIL imply_flags got iv=%0d cf=%0d exp iv=1 cf=0", ob_valid, ob_conf); end
    checks++;
    if (ob_ivar !== ex_ivar || ob_ival !== ex_ival || ob_ilvl !== ex_ilvl || ob_icid !== ex_icid) begin
      failures++; $display("FAIL imply_fields got var=%0d val=%0d lvl=%0d cid=%0d exp var=%0d val=%0d lvl=%0d cid=%0d",
                           ob_ivar, ob_ival, ob_ilvl, ob_icid, ex_ivar, ex_ival, ex_ilvl, ex_icid);
    end
    checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL imply_reason_len got=%h exp=%h", clause_len_o, exp_lens()); end
    do_bkt(5);
    checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL bkt_same_lvl_len got=%h exp=%h", clause_len_o, exp_lens()); end
    do_bkt(4);
    checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL bkt_lower_lvl_len got=%h exp=%h", clause_len_o, exp_lens()); end
  endtask

  task automatic test_unit_then_conflict();
    wr_clause(0, '0, 4'd0);
    wr_clause(2, '0, 4'd0);
    wr_clause(1, mk(4, 2'b01) | mk(5, 2'b01), 4'd2);
    wr_clause(5, mk(6, 2'b10) | mk(7, 2'b01), 4'd2);
    for (int v = 0; v < NV; v++) begin m_val[v] = 2'b00; m_lvl[v] = 0; end
    m_val[4] = 2'b10; m_lvl[4] = 2; m_val[6] = 2'b01; m_lvl[6] = 4; m_val[7] = 2'b10; m_lvl[7] = 6;
    run_scan();
    checks++; if (ob_conf !== 1 || ob_valid !== 0) begin failures++; $display("FAIL uc_flags got cf=%0d iv=%0d exp cf=1 iv=0", ob_conf, ob_valid); end
    checks++; if (ob_ccid !== ex_ccid || ob_clvl !== ex_clvl) begin failures++; $display("FAIL uc_conflict got cid=%0d lvl=%0d exp cid=%0d lvl=%0d", ob_ccid, ob_clvl, ex_ccid, ex_clvl); end
    checks++; if (ob_cyc !== ex_cyc) begin failures++; $display("FAIL uc_done_cycle got=%0d exp=%0d", ob_cyc, ex_cyc); end
    checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL uc_no_reason got=%h exp=%h", clause_len_o, exp_lens()); end
  endtask

  task automatic test_all_sat_and_reset();
    int seen;
    m_val[4] = 2'b01; m_lvl[4] = 1; m_val[6] = 2'b10; m_lvl[6] = 1;
    run_scan();
    checks++; if (ob_sat !== 1 || ob_conf !== 0 || ob_valid !== 0) begin failures++; $display("FAIL allsat got sat=%0d cf=%0d iv=%0d exp 1 0 0", ob_sat, ob_conf, ob_valid); end
    checks++; if (ob_busy1 !== 1 || ob_done2 !== 0 || ob_busy2 !== 0) begin failures++; $display("FAIL allsat_handshake got busy1=%0d done2=%0d busy2=%0d exp 1 0 0", ob_busy1, ob_done2, ob_busy2); end
    drive_vars();
    apply_imply_i = 1'b1;
    @(posedge clk); @(negedge clk);
    apply_imply_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    model_clear();
    checks++;
    if ({busy_o, done_o, imply_valid_o, conflict_o, all_c_sat_o, clause_len_o} !== '0) begin
      failures++; $display("FAIL midscan_reset got busy=%b done=%b sat=%b len=%h exp all 0", busy_o, done_o, all_c_sat_o, clause_len_o);
    end
    seen = 0;
    for (int c = 0; c < NC + 3; c++) begin
      if (done_o !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midscan_reset_done got=%0d pulses exp=0", seen); end
  endtask

  task automatic test_write_busy_read();
    logic [NV*2-1:0] exp_or;
    int cyc;
    wr_clause(0, mk(0, 2'b01) | mk(1, 2'b10), 4'd2);
    wr_clause(2, mk(3, 2'b10) | mk(5, 2'b01), 4'd3);
    checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL write_len_visible got=%h exp=%h", clause_len_o, exp_lens()); end
    rd_i = 8'b0000_0101; exp_or = m_clause[0] | m_clause[2];
    #1;
    checks++; if (clause_o !== exp_or) begin failures++; $display("FAIL read_or got=%h exp=%h", clause_o, exp_or); end
    rd_i = '0;
    #1;
    checks++; if (clause_o !== '0) begin failures++; $display("FAIL read_none got=%h exp=0", clause_o); end
    drive_vars();
    model_scan();
    apply_imply_i = 1'b1;
    @(posedge clk); @(negedge clk);
    apply_imply_i = 1'b0;
    wr_i = 8'b0000_0100; clause_i = mk(7, 2'b01); clause_len_i = 4'd9;
    @(posedge clk); @(negedge clk);
    wr_i = '0;
    cyc = -1;
    for (int c = 2; c <= NC + 4; c++) begin
      if (done_o === 1'b1) begin cyc = c; break; end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (cyc !== ex_cyc) begin failures++; $display("FAIL busy_write_done_cycle got=%0d exp=%0d", cyc, ex_cyc); end
    @(posedge clk); @(negedge clk);
    if (ex_valid) begin r_flag[ex_icid] = 1; r_lvl[ex_icid] = ex_ilvl; end
    rd_i = 8'b0000_0100;
    #1;
    checks++; if (clause_o !== m_clause[2] || clause_len_o !== exp_lens()) begin failures++; $display("FAIL busy_write_ignored got=%h len=%h exp=%h len=%h", clause_o, clause_len_o, m_clause[2], exp_lens()); end
    rd_i = '0;
  endtask

  task automatic test_bkt_abort_and_simul();
    int seen;
    for (int v = 0; v < NV; v++) begin m_val[v] = 2'b00; m_lvl[v] = 0; end
    m_val[0] = 2'b10; m_lvl[0] = 3; m_val[3] = 2'b01; m_lvl[3] = 1;
    drive_vars();
    apply_imply_i = 1'b1;
    @(posedge clk); @(negedge clk);
    apply_imply_i = 1'b0;
    @(posedge clk); @(negedge clk);
    do_bkt(0);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    seen = 0;
    for (int c = 0; c < NC + 2; c++) begin
      if (done_o !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (seen !== 0 || imply_valid_o !== 1'b0 || conflict_o !== 1'b0 || all_c_sat_o !== 1'b0) begin
      failures++; $display("FAIL abort_results got done_pulses=%0d iv=%b cf=%b sat=%b exp 0 0 0 0", seen, imply_valid_o, conflict_o, all_c_sat_o);
    end
    run_scan();
    checks++; if (ob_valid !== 1 || ob_icid !== ex_icid || clause_len_o !== exp_lens()) begin
      failures++; $display("FAIL reason_setup got iv=%0d cid=%0d len=%h exp iv=1 cid=%0d len=%h", ob_valid, ob_icid, clause_len_o, ex_icid, exp_lens());
    end
    apply_imply_i = 1'b1;
    do_bkt(2);
    apply_imply_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || clause_len_o !== exp_lens()) begin
      failures++; $display("FAIL simul_imply_bkt got busy=%b len=%h exp busy=0 len=%h", busy_o, clause_len_o, exp_lens());
    end
  endtask

  task automatic test_random();
    int n, slot, r;
    logic [NV*2-1:0] lits;
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        slot = $urandom_range(0, NC - 1);
        lits = '0;
        for (int v = 0; v < NV; v++) begin
          r = $urandom_range(0, 8);
          lits[2*v +: 2] = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
        end
        wr_clause(slot, lits, WCL'($urandom_range(0, 15)));
      end
      for (int v = 0; v < NV; v++) begin
        r = $urandom_range(0, 7);
        m_val[v] = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
        m_lvl[v] = $urandom_range(0, 20);
      end
      run_scan();
      checks++; if (ob_cyc !== ex_cyc) begin failures++; $display("FAIL rnd%0d done_cycle got=%0d exp=%0d", it, ob_cyc, ex_cyc); end
      checks++; if (ob_busy1 !== 1 || ob_done2 !== 0 || ob_busy2 !== 0) begin failures++; $display("FAIL rnd%0d handshake got busy1=%0d done2=%0d busy2=%0d exp 1 0 0", it, ob_busy1, ob_done2, ob_busy2); end
      checks++; if (ob_conf !== int'(ex_conf) || ob_valid !== int'(ex_valid) || ob_sat !== int'(ex_sat)) begin
        failures++; $display("FAIL rnd%0d flags got cf=%0d iv=%0d sat=%0d exp cf=%0d iv=%0d sat=%0d", it, ob_conf, ob_valid, ob_sat, ex_conf, ex_valid, ex_sat);
      end
      if (ex_conf) begin
        checks++; if (ob_ccid !== ex_ccid || ob_clvl !== ex_clvl) begin failures++; $display("FAIL rnd%0d conflict got cid=%0d lvl=%0d exp cid=%0d lvl=%0d", it, ob_ccid, ob_clvl, ex_ccid, ex_clvl); end
      end
      if (ex_valid) begin
        checks++;
        if (ob_ivar !== ex_ivar || ob_ival !== ex_ival || ob_ilvl !== ex_ilvl || ob_icid !== ex_icid) begin
          failures++; $display("FAIL rnd%0d imply got var=%0d val=%0d lvl=%0d cid=%0d exp var=%0d val=%0d lvl=%0d cid=%0d",
                               it, ob_ivar, ob_ival, ob_ilvl, ob_icid, ex_ivar, ex_ival, ex_ilvl, ex_icid);
        end
      end
      checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL rnd%0d lens got=%h exp=%h", it, clause_len_o, exp_lens()); end
      if ($urandom_range(0, 2) == 0) begin
        do_bkt($urandom_range(0, 20));
        checks++; if (clause_len_o !== exp_lens()) begin failures++; $display("FAIL rnd%0d bkt_lens got=%h exp=%h", it, clause_len_o, exp_lens()); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_conflict();
    test_imply_bkt();
    test_unit_then_conflict();
    test_all_sat_and_reset();
    test_write_busy_read();
    test_bkt_abort_and_simul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clause_array_scan.md
# clause_array_scan

Parametrised clause store and sequential BCP evaluator for the SAT engine. Holds NUM_CLAUSES clauses of up to NUM_VARS literals each. On an imply request it scans every clause against a snapshot of the variable assignment and reports one implication or one conflict with its decision level. It tracks reason clauses across backtracks and supersedes the single-clause cell in the clause array.

## Interface
- NUM_VARS, 8, variables/literal slots per clause
- NUM_CLAUSES, 8, clause slots; CID_W = max(1,$clog2(NUM_CLAUSES)), VID_W = max(1,$clog2(NUM_VARS))
- WIDTH_LVL, 16, decision-level width
- WIDTH_C_LEN, 4, clause-length field width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- var_value_i  in  NUM_VARS*3  per-var value: [1:0] 00 free, 01 true, 10 false, 11 treated as free; [2] ignored
- var_lvl_i  in  NUM_VARS*WIDTH_LVL  per-var decision level
- wr_i  in  NUM_CLAUSES  one-hot clause write strobe
- rd_i  in  NUM_CLAUSES  clause read select
- clause_i  in  NUM_VARS*2  literals: 00 absent, 01 positive, 10 negative, 11 absent
- clause_len_i  in  WIDTH_C_LEN  length of written clause
- clause_o  out  NUM_VARS*2  OR of literals of all rd_i-selected clauses, 0 if none
- clause_len_o  out  WIDTH_C_LEN*NUM_CLAUSES  per-slot length, 0 while slot is a reason
- apply_imply_i  in  1  start scan
- apply_bkt_i  in  1  backtrack to bkt_lvl_i
- bkt_lvl_i  in  WIDTH_LVL  backtrack target level
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle scan-complete pulse
- imply_valid_o / conflict_o  out  1 / 1  result flags, held until next scan start
- imply_var_o  out  VID_W; imply_value_o  out  2  (01 or 10, value making the literal true)
- imply_lvl_o / conflict_lvl_o  out  WIDTH_LVL  result level
- imply_cid_o / conflict_cid_o  out  CID_W  clause index
- all_c_sat_o  out  1  every non-empty clause satisfied at last scan

## Operation
- Literal true: lit 01 & val 01, or lit 10 & val 10. Literal false: present and val opposite. Literal free: present and val free.
- Clause empty: all literals absent. Satisfied: any literal true. Unit: not satisfied, exactly one free literal. Conflicting: non-empty, not satisfied, zero free literals.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE: wr_i stores clause_i and clause_len_i into the slot and clears its reason flag. rd_i is served combinationally. apply_imply_i latches the var_value_i/var_lvl_i snapshot, clears results, sets idx=0, enters SCAN.
- SCAN: evaluates clause idx per cycle, idx+1 each cycle. Records first (lowest idx) conflict and first unit clause.
  - imply lvl: max level of the clause's false literals, 0 if none.
  - conflict lvl: max level over all literals.
  - Reason clauses are still evaluated normally.
- SCAN exits after idx=NUM_CLAUSES-1 and enters DONE.
- DONE: done_o=1 for one cycle, then IDLE.
  - Conflict found: conflict_o=1, imply_valid_o=0, and results are held.
  - Otherwise a unit clause found: imply_valid_o=1, its slot's reason flag is set, and imply_lvl_o is stored as the slot's reason level.
  - all_c_sat_o updates.
- apply_bkt_i, any state: clears the reason flag of every slot whose reason level > bkt_lvl_i. If busy, it aborts the scan to IDLE, with no done_o and results left 0.
- Ignored while busy: wr_i, rd_i (clause_o still driven), apply_imply_i.
- Simultaneous apply_imply_i and apply_bkt_i in IDLE: backtrack applied, scan not started.

## Timing
- Reset: all outputs 0, all slots empty, reason flags 0, state IDLE.
- A reset mid-scan returns to IDLE immediately with no done_o.
- apply_imply_i sampled at edge 0. SCAN occupies cycles 1..NUM_CLAUSES. done_o and results are valid in cycle NUM_CLAUSES+1. The next apply_imply_i is accepted from cycle NUM_CLAUSES+2.
- busy_o=1 in SCAN and DONE.
- Write visible to clause_o/clause_len_o the cycle after wr_i.

## Configuration
- CLAUSE_ARRAY_EARLY_EXIT_EN defined: SCAN leaves at the first conflicting clause k, and done_o occurs in cycle k+2. all_c_sat_o is then 0.
- Undefined: a full scan always runs, with fixed latency NUM_CLAUSES+1.

## Test plan
- Write c0=(x0 | ~x1), x0=10 lvl3, x1=01 lvl2, scan -> conflict_o=1, cid 0, conflict_lvl_o=3, done_o at cycle 9 (N=8).
- c2=(x0 | x3), x0=10 lvl5, x3 free -> imply_valid_o=1, var 3, value 01, lvl 5, cid 2, clause_len_o slot2=0.
- Same state, apply_bkt_i with bkt_lvl_i=4 -> slot2 reason cleared, clause_len_o slot2=2; with bkt_lvl_i=5 -> unchanged.
- Unit in c1 and conflict in c5 -> conflict_o=1, cid 5, imply_valid_o=0. With EARLY_EXIT_EN, done_o at cycle 7.
- All clauses satisfied -> all_c_sat_o=1, both flags 0. Then rst=0 mid-scan -> all outputs 0, no done_o.
- wr_i during SCAN -> slot unchanged. rd_i=0b101 -> clause_o = c0|c2.
